branch_predictor: RTL and testbench

Dynamic conditional-branch predictor for the RISC-V core. It sits at the fetch end of the branch path: fetch queries it with a PC and gets a taken/not-taken guess one cycle later. The execute stage feeds back each resolved B-type outcome (the branch-taken result from branch resolution) to train the table. It also flags and counts mispredictions.

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter conditional-branch predictor with same-cycle training bypass.
// Define BP_GSHARE_EN to XOR a non-speculative global history into the table index.
module branch_predictor #(
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned HIST_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             lkp_valid_i,
   input  logic [63:0]      lkp_pc_i,
   output logic             pred_valid_o,
   output logic             pred_taken_o,
   output logic [IDX_W-1:0] pred_idx_o,
   input  logic             upd_valid_i,
   input  logic             upd_is_b_type_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_pred_taken_i,
   input  logic             upd_taken_i,
   output logic             mispredict_o,
   output logic [31:0]      mispred_cnt_o
);

   localparam int unsigned ENTRIES = 1 << IDX_W;

   logic [1:0]       pht [ENTRIES];
   logic             train;
   logic [IDX_W-1:0] lkp_idx;
   logic [1:0]       upd_ctr;
   logic [1:0]       upd_ctr_nxt;
   logic [1:0]       lkp_ctr;
   logic             pred_valid_q;
   logic             pred_taken_q;
   logic [IDX_W-1:0] pred_idx_q;
   logic             mispredict_q;
   logic [31:0]      mispred_cnt_q;
   logic             unused_pc_bits;

   assign train          = upd_valid_i & upd_is_b_type_i;
   assign unused_pc_bits = ^{lkp_pc_i[63:IDX_W+2], lkp_pc_i[1:0]};

`ifdef BP_GSHARE_EN
   logic [HIST_W-1:0] ghr_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ghr_q <= '0;
      end else if (train) begin
         ghr_q <= HIST_W'({ghr_q, upd_taken_i});
      end
   end

   assign lkp_idx = lkp_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
   localparam int unsigned HIST_W_UNUSED = HIST_W;

   assign lkp_idx = lkp_pc_i[IDX_W+1:2];
`endif

   always_comb begin
      upd_ctr     = pht[upd_idx_i];
      upd_ctr_nxt = upd_ctr;
      if (upd_taken_i) begin
         if (upd_ctr != 2'b11) upd_ctr_nxt = upd_ctr + 2'd1;
      end else begin
         if (upd_ctr != 2'b00) upd_ctr_nxt = upd_ctr - 2'd1;
      end
   end

   // A same-cycle train to the looked-up entry forwards its new value.
   always_comb begin
      lkp_ctr = pht[lkp_idx];
      if (train && (upd_idx_i == lkp_idx)) lkp_ctr = upd_ctr_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            pht[IDX_W'(i)] <= 2'b01;
         end
      end else if (train) begin
         pht[upd_idx_i] <= upd_ctr_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_idx_q    <= '0;
         mispredict_q  <= 1'b0;
         mispred_cnt_q <= '0;
      end else begin
         pred_valid_q <= lkp_valid_i;
         if (lkp_valid_i) begin
            pred_taken_q <= lkp_ctr[1];
            pred_idx_q   <= lkp_idx;
         end
         mispredict_q <= train & (upd_pred_taken_i != upd_taken_i);
         if (train && (upd_pred_taken_i != upd_taken_i) && (mispred_cnt_q != '1)) begin
            mispred_cnt_q <= mispred_cnt_q + 32'd1;
         end
      end
   end

   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign pred_idx_o    = pred_idx_q;
   assign mispredict_o  = mispredict_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; honours BP_GSHARE_EN for index expectations.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        lkp_valid_i = 1'b0;
   logic [63:0] lkp_pc_i = '0;
   logic        pred_valid_o;
   logic        pred_taken_o;
   logic [5:0]  pred_idx_o;
   logic        upd_valid_i = 1'b0;
   logic        upd_is_b_type_i = 1'b0;
   logic [5:0]  upd_idx_i = '0;
   logic        upd_pred_taken_i = 1'b0;
   logic        upd_taken_i = 1'b0;
   logic        mispredict_o;
   logic [31:0] mispred_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [5:0] m_ghr = '0;

   branch_predictor #(.IDX_W(6), .HIST_W(6)) dut (
      .clk(clk), .resetn(resetn),
      .lkp_valid_i(lkp_valid_i), .lkp_pc_i(lkp_pc_i),
      .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_idx_o(pred_idx_o),
      .upd_valid_i(upd_valid_i), .upd_is_b_type_i(upd_is_b_type_i), .upd_idx_i(upd_idx_i),
      .upd_pred_taken_i(upd_pred_taken_i), .upd_taken_i(upd_taken_i),
      .mispredict_o(mispredict_o), .mispred_cnt_o(mispred_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      lkp_valid_i = 1'b0; upd_valid_i = 1'b0; upd_is_b_type_i = 1'b0;
      upd_pred_taken_i = 1'b0; upd_taken_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetn = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      m_ghr = '0;
   endtask

   // PC whose effective index (after the history XOR, if any) is idx.
   function automatic logic [63:0] pc_for(input logic [5:0] idx);
      logic [5:0] base;
`ifdef BP_GSHARE_EN
      base = idx ^ m_ghr;
`else
      base = idx;
`endif
      return {56'd0, base, 2'b00};
   endfunction

   task automatic set_train(input logic [5:0] idx, input logic taken, input logic pred);
      upd_valid_i = 1'b1; upd_is_b_type_i = 1'b1; upd_idx_i = idx;
      upd_taken_i = taken; upd_pred_taken_i = pred;
   endtask

   task automatic model_train(input logic taken);
`ifdef BP_GSHARE_EN
      m_ghr = {m_ghr[4:0], taken};
`endif
   endtask

   task automatic train(input logic [5:0] idx, input logic taken, input logic pred);
      set_train(idx, taken, pred);
      tick();
      model_train(taken);
      clear_inputs();
   endtask

   task automatic lookup(input logic [63:0] pc);
      lkp_valid_i = 1'b1; lkp_pc_i = pc;
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      resetn = 1'b0;
      #3;
      n_checks++; if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", pred_valid_o); end
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL rst_taken got %0b want 0", pred_taken_o); end
      n_checks++; if (pred_idx_o !== 6'h00) begin n_fail++; $display("FAIL rst_idx got %h want 00", pred_idx_o); end
      n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL rst_mispred got %0b want 0", mispredict_o); end
      n_checks++; if (mispred_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got %h want 0", mispred_cnt_o); end
      do_reset();
      lookup(64'h100);
      n_checks++; if (pred_valid_o !== 1'b1) begin n_fail++; $display("FAIL dflt_valid got %0b want 1", pred_valid_o); end
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL dflt_taken got %0b want 0", pred_taken_o); end
      n_checks++; if (pred_idx_o !== 6'h00) begin n_fail++; $display("FAIL dflt_idx got %h want 00", pred_idx_o); end
      lookup(64'h10C);
      tick();
      n_checks++; if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %0b want 0", pred_valid_o); end
      n_checks++; if (pred_idx_o !== 6'h03) begin n_fail++; $display("FAIL idle_hold_idx got %h want 03", pred_idx_o); end
   endtask

   task automatic test_saturating();
      do_reset();
      train(6'h00, 1'b1, 1'b1);
      lookup(pc_for(6'h00));
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL sat_t1 got %0b want 1", pred_taken_o); end
      n_checks++; if (pred_idx_o !== 6'h00) begin n_fail++; $display("FAIL sat_idx got %h want 00", pred_idx_o); end
      for (int i = 0; i < 3; i++) train(6'h00, 1'b1, 1'b1);
      train(6'h00, 1'b0, 1'b1);
      lookup(pc_for(6'h00));
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL sat_hi got %0b want 1", pred_taken_o); end
      train(6'h00, 1'b0, 1'b1);
      lookup(pc_for(6'h00));
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL sat_nt got %0b want 0", pred_taken_o); end
      for (int i = 0; i < 3; i++) train(6'h00, 1'b0, 1'b0);
      train(6'h00, 1'b1, 1'b0);
      lookup(pc_for(6'h00));
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL sat_lo got %0b want 0", pred_taken_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      train(6'h05, 1'b1, 1'b1);
      train(6'h05, 1'b1, 1'b1);
      train(6'h05, 1'b0, 1'b1);
      lookup(pc_for(6'h05));
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL b2b_taken got %0b want 1", pred_taken_o); end
   endtask

   task automatic test_mispredict();
      do_reset();
      train(6'h02, 1'b1, 1'b0);
      n_checks++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL mp_pulse got %0b want 1", mispredict_o); end
      n_checks++; if (mispred_cnt_o !== 32'd1) begin n_fail++; $display("FAIL mp_cnt got %h want 1", mispred_cnt_o); end
      tick();
      n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL mp_one_cycle got %0b want 0", mispredict_o); end
      train(6'h02, 1'b1, 1'b1);
      n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL mp_match got %0b want 0", mispredict_o); end
      n_checks++; if (mispred_cnt_o !== 32'd1) begin n_fail++; $display("FAIL mp_match_cnt got %h want 1", mispred_cnt_o); end
      train(6'h02, 1'b0, 1'b1);
      n_checks++; if (mispred_cnt_o !== 32'd2) begin n_fail++; $display("FAIL mp_cnt2 got %h want 2", mispred_cnt_o); end
      force dut.mispred_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.mispred_cnt_q;
      train(6'h02, 1'b1, 1'b0);
      n_checks++; if (mispred_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mp_to_max got %h want ffffffff", mispred_cnt_o); end
      train(6'h02, 1'b1, 1'b0);
      n_checks++; if (mispred_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mp_sat got %h want ffffffff", mispred_cnt_o); end
      n_checks++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL mp_sat_pulse got %0b want 1", mispredict_o); end
   endtask

   task automatic test_bypass();
      do_reset();
      lkp_valid_i = 1'b1; lkp_pc_i = pc_for(6'h01);
      set_train(6'h01, 1'b1, 1'b1);
      tick();
      model_train(1'b1);
      clear_inputs();
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL byp_taken got %0b want 1", pred_taken_o); end
      n_checks++; if (pred_idx_o !== 6'h01) begin n_fail++; $display("FAIL byp_idx got %h want 01", pred_idx_o); end
      for (int i = 0; i < 3; i++) begin
         upd_valid_i = 1'b1; upd_is_b_type_i = 1'b0; upd_idx_i = 6'h03;
         upd_taken_i = 1'b1; upd_pred_taken_i = 1'b0;
         tick();
      end
      clear_inputs();
      n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL nonb_pulse got %0b want 0", mispredict_o); end
      n_checks++; if (mispred_cnt_o !== 32'd0) begin n_fail++; $display("FAIL nonb_cnt got %h want 0", mispred_cnt_o); end
      lookup(pc_for(6'h03));
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL nonb_table got %0b want 0", pred_taken_o); end
      n_checks++; if (pred_idx_o !== 6'h03) begin n_fail++; $display("FAIL nonb_idx got %h want 03", pred_idx_o); end
   endtask

   task automatic test_gshare();
      logic [5:0] exp_idx;
      logic       exp_taken;
`ifdef BP_GSHARE_EN
      exp_idx = 6'h03; exp_taken = 1'b0;
`else
      exp_idx = 6'h00; exp_taken = 1'b1;
`endif
      do_reset();
      train(6'h00, 1'b1, 1'b1);
      train(6'h00, 1'b1, 1'b1);
      lookup(64'h100);
      n_checks++; if (pred_idx_o !== exp_idx) begin n_fail++; $display("FAIL gs_idx got %h want %h", pred_idx_o, exp_idx); end
      n_checks++; if (pred_taken_o !== exp_taken) begin n_fail++; $display("FAIL gs_taken got %0b want %0b", pred_taken_o, exp_taken); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      train(6'h00, 1'b1, 1'b1);
      train(6'h00, 1'b1, 1'b1);
      lkp_valid_i = 1'b1; lkp_pc_i = pc_for(6'h00);
      set_train(6'h07, 1'b1, 1'b0);
      tick();
      #2;
      resetn = 1'b0;
      #1;
      n_checks++; if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %0b want 0", pred_valid_o); end
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL mid_taken got %0b want 0", pred_taken_o); end
      n_checks++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL mid_mispred got %0b want 0", mispredict_o); end
      n_checks++; if (mispred_cnt_o !== 32'd0) begin n_fail++; $display("FAIL mid_cnt got %h want 0", mispred_cnt_o); end
      tick();
      n_checks++; if (pred_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_ignored got %0b want 0", pred_valid_o); end
      clear_inputs();
      resetn = 1'b1;
      m_ghr = '0;
      lookup(64'h100);
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL mid_post_taken got %0b want 0", pred_taken_o); end
      n_checks++; if (pred_idx_o !== 6'h00) begin n_fail++; $display("FAIL mid_post_idx got %h want 00", pred_idx_o); end
   endtask

   initial begin
      test_reset();
      test_saturating();
      test_back_to_back();
      test_mispredict();
      test_bypass();
      test_gshare();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
